axi_burst_master: RTL

//  Directed AXI3 traffic generator that sits directly upstream of the AXI memory model and drives its AXI slave port.
//  - Write commands: issues one INCR burst of a seeded incrementing data pattern.
//  - Read commands: issues one INCR burst and checks the returned data against the same pattern.
//  - One outstanding transaction at a time; used by the testbench to preload and verify external memory.

---
 rtl/axi_burst_master_if.sv | 80 ++++++++
 rtl/axi_burst_master.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/axi_burst_master_if.sv
// Command/status and AXI3 master port bundle for axi_burst_master.
// master = the traffic generator side, slave = command source plus memory model side.
interface axi_burst_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_write_i;
  logic [ADDR_WIDTH-1:0]   cmd_addr_i;
  logic [3:0]              cmd_len_i;
  logic [DATA_WIDTH-1:0]   cmd_seed_i;
  logic                    done_o;
  logic                    err_o;
  logic [15:0]             mismatch_cnt_o;

  logic [7:0]              axi_awid_o;
  logic [ADDR_WIDTH-1:0]   axi_awaddr_o;
  logic [3:0]              axi_awlen_o;
  logic [2:0]              axi_awsize_o;
  logic [1:0]              axi_awburst_o;
  logic                    axi_awvalid_o;
  logic                    axi_awready_i;

  logic [DATA_WIDTH-1:0]   axi_wdata_o;
  logic [DATA_WIDTH/8-1:0] axi_wstrb_o;
  logic                    axi_wlast_o;
  logic                    axi_wvalid_o;
  logic                    axi_wready_i;

  logic [7:0]              axi_bid_i;
  logic [1:0]              axi_bresp_i;
  logic                    axi_bvalid_i;
  logic                    axi_bready_o;

  logic [7:0]              axi_arid_o;
  logic [ADDR_WIDTH-1:0]   axi_araddr_o;
  logic [3:0]              axi_arlen_o;
  logic [2:0]              axi_arsize_o;
  logic [1:0]              axi_arburst_o;
  logic                    axi_arvalid_o;
  logic                    axi_arready_i;

  logic [7:0]              axi_rid_i;
  logic [DATA_WIDTH-1:0]   axi_rdata_i;
  logic [1:0]              axi_rresp_i;
  logic                    axi_rlast_i;
  logic                    axi_rvalid_i;
  logic                    axi_rready_o;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i, cmd_seed_i,
    output cmd_ready_o, done_o, err_o, mismatch_cnt_o,
    output axi_awid_o, axi_awaddr_o, axi_awlen_o, axi_awsize_o, axi_awburst_o, axi_awvalid_o,
    input  axi_awready_i,
    output axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
    input  axi_wready_i,
    input  axi_bid_i, axi_bresp_i, axi_bvalid_i,
    output axi_bready_o,
    output axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o, axi_arvalid_o,
    input  axi_arready_i,
    input  axi_rid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i,
    output axi_rready_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i, cmd_seed_i,
    input  cmd_ready_o, done_o, err_o, mismatch_cnt_o,
    input  axi_awid_o, axi_awaddr_o, axi_awlen_o, axi_awsize_o, axi_awburst_o, axi_awvalid_o,
    output axi_awready_i,
    input  axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
    output axi_wready_i,
    output axi_bid_i, axi_bresp_i, axi_bvalid_i,
    input  axi_bready_o,
    input  axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o, axi_arvalid_o,
    output axi_arready_i,
    output axi_rid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i,
    input  axi_rready_o
  );
endinterface

// File: rtl/axi_burst_master.sv
// Directed AXI3 burst generator: writes a seeded incrementing pattern, or reads
// a burst back and checks it against the same pattern. One transaction at a time.
module axi_burst_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [7:0]  AXI_ID     = 8'h00
) (
  input  logic               axi_clk_i,
  input  logic               rst_n_i,
  axi_burst_master_if.master bus
);

  localparam int unsigned           SIZE      = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~((ADDR_WIDTH'(1) << SIZE) - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  ready_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            len_q;
  logic [3:0]            beat_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  err_q;
  logic [15:0]           mism_q;

  logic                  accept;
  logic                  w_hs;
  logic                  b_hs;
  logic                  r_hs;
  logic                  last_beat;
  logic                  r_end;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  r_mis;
  logic                  r_meta_err;
  logic                  b_err;

  assign accept     = bus.cmd_valid_i && bus.cmd_ready_o;
  assign w_hs       = (state_q == WR_DATA) && bus.axi_wready_i;
  assign b_hs       = (state_q == WR_RESP) && bus.axi_bvalid_i;
  assign r_hs       = (state_q == RD_DATA) && bus.axi_rvalid_i;
  assign last_beat  = (beat_q == len_q);
  assign r_end      = bus.axi_rlast_i || last_beat;
  assign exp_data   = seed_q + DATA_WIDTH'(beat_q);
  assign r_mis      = (bus.axi_rdata_i != exp_data);
  assign r_meta_err = (bus.axi_rresp_i != 2'b00) || (bus.axi_rid_i != AXI_ID) ||
                      (bus.axi_rlast_i != last_beat);
  assign b_err      = (bus.axi_bresp_i != 2'b00) || (bus.axi_bid_i != AXI_ID);

  // Outputs decode from state so that a reset edge forces every valid low at once.
  assign bus.cmd_ready_o    = (state_q == IDLE) && ready_en_q;
  assign bus.done_o         = (state_q == DONE);
  assign bus.err_o          = (state_q == DONE) && err_q;
  assign bus.mismatch_cnt_o = mism_q;

  assign bus.axi_awid_o    = AXI_ID;
  assign bus.axi_awaddr_o  = addr_q;
  assign bus.axi_awlen_o   = len_q;
  assign bus.axi_awsize_o  = 3'(SIZE);
  assign bus.axi_awburst_o = 2'b01;
  assign bus.axi_awvalid_o = (state_q == WR_ADDR);

  assign bus.axi_wdata_o   = exp_data;
  assign bus.axi_wstrb_o   = '1;
  assign bus.axi_wlast_o   = last_beat;
  assign bus.axi_wvalid_o  = (state_q == WR_DATA);

  assign bus.axi_bready_o  = (state_q == WR_RESP);

  assign bus.axi_arid_o    = AXI_ID;
  assign bus.axi_araddr_o  = addr_q;
  assign bus.axi_arlen_o   = len_q;
  assign bus.axi_arsize_o  = 3'(SIZE);
  assign bus.axi_arburst_o = 2'b01;
  assign bus.axi_arvalid_o = (state_q == RD_ADDR);

  assign bus.axi_rready_o  = (state_q == RD_DATA);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)                state_d = bus.cmd_write_i ? WR_ADDR : RD_ADDR;
      WR_ADDR: if (bus.axi_awready_i)     state_d = WR_DATA;
      WR_DATA: if (w_hs && last_beat)     state_d = WR_RESP;
      WR_RESP: if (bus.axi_bvalid_i)      state_d = DONE;
      RD_ADDR: if (bus.axi_arready_i)     state_d = RD_DATA;
      RD_DATA: if (r_hs && r_end)         state_d = DONE;
      DONE:                               state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge axi_clk_i) begin
    if (!rst_n_i) begin
      addr_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
      seed_q <= '0;
      err_q  <= 1'b0;
      mism_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= bus.cmd_addr_i & ADDR_MASK;
        len_q  <= bus.cmd_len_i;
        seed_q <= bus.cmd_seed_i;
        beat_q <= '0;
        err_q  <= 1'b0;
      end
      if (w_hs && !last_beat) begin
        beat_q <= beat_q + 4'd1;
      end
      if (b_hs && b_err) begin
        err_q <= 1'b1;
      end
      if (r_hs) begin
        if (!r_end) begin
          beat_q <= beat_q + 4'd1;
        end
        if (r_mis || r_meta_err) begin
          err_q <= 1'b1;
        end
        if (r_mis && (mism_q != '1)) begin
          mism_q <= mism_q + 16'd1;
        end
      end
    end
  end

endmodule
